// File: rtl/sprite_tile_latch.sv
// sprite_tile_latch: captures a sprite tile's VRAM word pair (tile LSBs, then
// the attribute word), applies auto-animation substitution to the low tile
// bits and queues the decoded descriptor for the C-ROM fetch stage.
//
// Optional build macro AA_LINE_LATCH_EN: when defined, the animation frame is
// latched from AA_COUNT on each LINE_START pulse so every tile of a line uses
// the same frame. When undefined, AA_COUNT is used directly at the LOAD_HI edge.
//
// Handshake: TILE_VALID is high while the queue holds at least one entry; the
// head entry is popped on a rising edge where TILE_VALID=1 and TILE_ACK=1.
// Head outputs stay stable until that pop. TILE_ACK while empty is ignored.
module sprite_tile_latch #(
  parameter int DEPTH  = 2,
  parameter int TILE_W = 20
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic [15:0]       VRAM_DATA,
  input  logic              LOAD_LO,
  input  logic              LOAD_HI,
  input  logic [2:0]        AA_COUNT,
  input  logic              AA_DISABLE,
  input  logic              LINE_START,
  input  logic              FLUSH,
  output logic [TILE_W-1:0] TILE,
  output logic [7:0]        PAL,
  output logic              FLIPX,
  output logic              FLIPY,
  output logic              TILE_VALID,
  input  logic              TILE_ACK,
  output logic              OVERFLOW
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = TILE_W + 10;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_HAVE_LO = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_push;
  logic              w_lo_load;
  logic [15:0]       r_lo;
  logic [2:0]        w_aa;
  logic [TILE_W-1:0] w_tile;
  logic [EW-1:0]     w_entry;

  logic [EW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     w_rd_nxt;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_pop;
  logic              w_full;
  logic              w_push_ok;
  logic              w_drop;
  logic [EW-1:0]     w_head_nxt;
  logic [EW-1:0]     r_head;
  logic              r_ovf;

`ifdef AA_LINE_LATCH_EN
  logic [2:0] r_aa;

  // Latch the animation frame once per sprite line.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)         r_aa <= 3'd0;
    else if (LINE_START) r_aa <= AA_COUNT;
  end

  assign w_aa = r_aa;
`else
  logic w_unused_line_start;
  assign w_unused_line_start = LINE_START;
  assign w_aa = AA_COUNT;
`endif

  // Capture FSM state and LO word register.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= ST_IDLE;
      r_lo    <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      if (w_lo_load) r_lo <= VRAM_DATA;
    end
  end

  // Next-state decode: LOAD_HI wins over LOAD_LO, FLUSH wins over both.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_lo_load   = 1'b0;
    if (FLUSH) begin
      w_state_nxt = ST_IDLE;
    end else if (LOAD_HI) begin
      if (r_state == ST_HAVE_LO) begin
        w_push      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    end else if (LOAD_LO) begin
      w_lo_load   = 1'b1;
      w_state_nxt = ST_HAVE_LO;
    end
  end

  // Descriptor build with auto-anim substitution (AA8 has priority over AA4).
  always_comb begin
    w_tile = {VRAM_DATA[7:4], r_lo};
    if (!AA_DISABLE) begin
      if (VRAM_DATA[3])      w_tile[2:0] = w_aa;
      else if (VRAM_DATA[2]) w_tile[1:0] = w_aa[1:0];
    end
    w_entry = {w_tile, VRAM_DATA[15:8], VRAM_DATA[1], VRAM_DATA[0]};
  end

  assign w_pop     = (r_count != '0) && TILE_ACK;
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;
  assign w_rd_nxt  = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;

  // Occupancy update and next head entry (bypass when the new head is being written).
  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push_ok && !w_pop)      w_cnt_nxt = r_count + CW'(1);
    else if (!w_push_ok && w_pop) w_cnt_nxt = r_count - CW'(1);
    if (w_push_ok && (w_rd_nxt == r_wr_ptr)) w_head_nxt = w_entry;
    else                                     w_head_nxt = r_mem[w_rd_nxt];
  end

  // Queue storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if (FLUSH) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Head output register: follows the queue head, holds its value when empty.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)                           r_head <= '0;
    else if (!FLUSH && (w_cnt_nxt != '0))  r_head <= w_head_nxt;
  end

  assign {TILE, PAL, FLIPY, FLIPX} = r_head;
  assign TILE_VALID = (r_count != '0);
  assign OVERFLOW   = r_ovf;

endmodule

// File: tb/tb_sprite_tile_latch.sv
// Bench for sprite_tile_latch: directed steps with a descriptor scoreboard.
module tb_sprite_tile_latch;

  logic        CLK;
  logic        nRESET;
  logic [15:0] VRAM_DATA;
  logic        LOAD_LO;
  logic        LOAD_HI;
  logic [2:0]  AA_COUNT;
  logic        AA_DISABLE;
  logic        LINE_START;
  logic        FLUSH;
  logic [19:0] TILE;
  logic [7:0]  PAL;
  logic        FLIPX;
  logic        FLIPY;
  logic        TILE_VALID;
  logic        TILE_ACK;
  logic        OVERFLOW;

  int n_cmp = 0;
  int n_err = 0;
  logic [29:0] exp_q[$];

  sprite_tile_latch #(.DEPTH(2), .TILE_W(20)) dut (
    .CLK(CLK), .nRESET(nRESET), .VRAM_DATA(VRAM_DATA), .LOAD_LO(LOAD_LO),
    .LOAD_HI(LOAD_HI), .AA_COUNT(AA_COUNT), .AA_DISABLE(AA_DISABLE),
    .LINE_START(LINE_START), .FLUSH(FLUSH), .TILE(TILE), .PAL(PAL),
    .FLIPX(FLIPX), .FLIPY(FLIPY), .TILE_VALID(TILE_VALID),
    .TILE_ACK(TILE_ACK), .OVERFLOW(OVERFLOW)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference descriptor: {tile[19:0], pal[7:0], flipy, flipx}
  function automatic logic [29:0] model(input logic [15:0] lo, input logic [15:0] attr,
                                        input logic [2:0] a, input logic dis);
    logic [19:0] t;
    t = {attr[7:4], lo};
    if (!dis && attr[3])      t[2:0] = a;
    else if (!dis && attr[2]) t[1:0] = a[1:0];
    return {t, attr[15:8], attr[1], attr[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Driver tasks
  task automatic drive_lo(input logic [15:0] lo, input logic [2:0] aa);
    VRAM_DATA = lo; LOAD_LO = 1'b1; AA_COUNT = aa; LINE_START = 1'b1;
    tick();
    LOAD_LO = 1'b0; LINE_START = 1'b0;
  endtask

  task automatic drive_hi(input logic [15:0] attr, input logic [2:0] aa,
                          input logic dis, input logic ack);
    VRAM_DATA = attr; LOAD_HI = 1'b1; AA_COUNT = aa; AA_DISABLE = dis; TILE_ACK = ack;
    tick();
    LOAD_HI = 1'b0; TILE_ACK = 1'b0; AA_DISABLE = 1'b0;
  endtask

  task automatic drive_pair(input logic [15:0] lo, input logic [15:0] attr,
                            input logic [2:0] aa, input logic dis, input logic ack);
    drive_lo(lo, aa);
    drive_hi(attr, aa, dis, ack);
  endtask

  // Scoreboard: compare head with the oldest expected entry
  task automatic check_head(input string tag);
    chk({tag, ".valid"}, {31'd0, TILE_VALID}, 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s.sb: observed empty scoreboard expected an entry", tag);
    end else begin
      chk({tag, ".desc"}, {2'b00, TILE, PAL, FLIPY, FLIPX}, {2'b00, exp_q[0]});
    end
  endtask

  task automatic pop_head(input string tag);
    check_head(tag);
    TILE_ACK = 1'b1;
    tick();
    TILE_ACK = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic flush_cycle();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
  endtask

  logic [15:0] lo_v [3];
  logic [15:0] at_v [3];
  logic [2:0]  aa_v [3];
  logic [29:0] last_e;
  logic [29:0] e_c;

  initial begin
    nRESET = 1'b0; VRAM_DATA = '0; LOAD_LO = 1'b0; LOAD_HI = 1'b0; AA_COUNT = '0;
    AA_DISABLE = 1'b0; LINE_START = 1'b0; FLUSH = 1'b0; TILE_ACK = 1'b0;

    // Reset state
    #12;
    chk("rst.valid", {31'd0, TILE_VALID}, 32'd0);
    chk("rst.tile",  {12'd0, TILE}, 32'd0);
    chk("rst.pal",   {24'd0, PAL}, 32'd0);
    chk("rst.flipx", {31'd0, FLIPX}, 32'd0);
    chk("rst.flipy", {31'd0, FLIPY}, 32'd0);
    chk("rst.ovf",   {31'd0, OVERFLOW}, 32'd0);
    @(negedge CLK);
    nRESET = 1'b1;
    tick();

    // AA8 substitution, 1-cycle latency, hold without ack
    exp_q.push_back({20'h31235, 8'h5A, 1'b0, 1'b0});
    drive_pair(16'h1234, 16'h5A38, 3'd5, 1'b0, 1'b0);
    check_head("aa8");
    tick();
    check_head("hold");
    pop_head("aa8_pop");
    chk("aa8.empty", {31'd0, TILE_VALID}, 32'd0);

    // Attribute 0x0007: AA4 with both flips
    exp_q.push_back({20'h01236, 8'h00, 1'b1, 1'b1});
    drive_pair(16'h1234, 16'h0007, 3'd6, 1'b0, 1'b0);
    pop_head("aa4_flip");

    // Same with substitution disabled
    exp_q.push_back({20'h01234, 8'h00, 1'b1, 1'b1});
    drive_pair(16'h1234, 16'h0007, 3'd6, 1'b1, 1'b0);
    pop_head("aa_dis");

    // Only bits [1:0] substituted
    exp_q.push_back({20'h0FFFE, 8'h00, 1'b0, 1'b0});
    drive_pair(16'hFFFF, 16'h0004, 3'd2, 1'b0, 1'b0);
    pop_head("aa4_lsb");

    // AA8 priority over AA4
    exp_q.push_back({20'h00007, 8'h00, 1'b0, 1'b0});
    drive_pair(16'h0000, 16'h000C, 3'd7, 1'b0, 1'b0);
    pop_head("aa_prio");

    // Overflow: three pushes into a two-entry queue
    for (int i = 0; i < 3; i++) begin
      lo_v[i] = 16'($urandom_range(0, 16'hFFFF));
      at_v[i] = 16'($urandom_range(0, 16'hFFFF));
      aa_v[i] = 3'($urandom_range(0, 7));
      if (i < 2) exp_q.push_back(model(lo_v[i], at_v[i], aa_v[i], 1'b0));
      drive_pair(lo_v[i], at_v[i], aa_v[i], 1'b0, 1'b0);
      if (i == 1) chk("fill.ovf", {31'd0, OVERFLOW}, 32'd0);
    end
    chk("ovf.set", {31'd0, OVERFLOW}, 32'd1);
    last_e = model(lo_v[1], at_v[1], aa_v[1], 1'b0);
    pop_head("ovf_e1");
    pop_head("ovf_e2");
    chk("ovf.empty", {31'd0, TILE_VALID}, 32'd0);
    chk("ovf.sticky", {31'd0, OVERFLOW}, 32'd1);
    flush_cycle();
    chk("flush.ovf", {31'd0, OVERFLOW}, 32'd0);
    chk("flush.valid", {31'd0, TILE_VALID}, 32'd0);
    chk("flush.hold", {2'b00, TILE, PAL, FLIPY, FLIPX}, {2'b00, last_e});

    // LOAD_HI with no preceding LOAD_LO
    drive_hi(16'h1238, 3'd1, 1'b0, 1'b0);
    chk("hi_only", {31'd0, TILE_VALID}, 32'd0);

    // Full queue: push and ack in the same cycle
    exp_q.push_back(model(16'hAAAA, 16'h1110, 3'd0, 1'b0));
    drive_pair(16'hAAAA, 16'h1110, 3'd0, 1'b0, 1'b0);
    exp_q.push_back(model(16'hBBBB, 16'h2221, 3'd0, 1'b0));
    drive_pair(16'hBBBB, 16'h2221, 3'd0, 1'b0, 1'b0);
    e_c = model(16'hCCC8, 16'h333E, 3'd5, 1'b0);
    check_head("full_a");
    drive_pair(16'hCCC8, 16'h333E, 3'd5, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back(e_c);
    chk("pushpop.ovf", {31'd0, OVERFLOW}, 32'd0);
    pop_head("full_b");
    pop_head("full_c");
    chk("full.empty", {31'd0, TILE_VALID}, 32'd0);

    // Asynchronous reset during HAVE_LO with an entry queued
    exp_q.push_back(model(16'h0101, 16'h4440, 3'd0, 1'b0));
    drive_pair(16'h0101, 16'h4440, 3'd0, 1'b0, 1'b0);
    drive_lo(16'h5555, 3'd0);
    #2 nRESET = 1'b0;
    #1;
    chk("arst.valid", {31'd0, TILE_VALID}, 32'd0);
    chk("arst.tile", {12'd0, TILE}, 32'd0);
    exp_q.delete();
    @(negedge CLK);
    nRESET = 1'b1;
    tick();
    drive_hi(16'h6660, 3'd0, 1'b0, 1'b0);
    chk("arst.hi_ignored", {31'd0, TILE_VALID}, 32'd0);

    // LOAD_LO and LOAD_HI together in HAVE_LO: HI uses the earlier LO word
    drive_lo(16'h00AB, 3'd0);
    VRAM_DATA = 16'h1230; LOAD_LO = 1'b1; LOAD_HI = 1'b1;
    tick();
    LOAD_LO = 1'b0; LOAD_HI = 1'b0;
    exp_q.push_back({20'h300AB, 8'h12, 1'b0, 1'b0});
    pop_head("both");
    drive_hi(16'h1230, 3'd0, 1'b0, 1'b0);
    chk("both.idle", {31'd0, TILE_VALID}, 32'd0);

    // Animation frame source: latched at LINE_START or live AA_COUNT
    AA_COUNT = 3'd3; LINE_START = 1'b1;
    tick();
    LINE_START = 1'b0; AA_COUNT = 3'd4; VRAM_DATA = 16'h0000; LOAD_LO = 1'b1;
    tick();
    LOAD_LO = 1'b0;
    drive_hi(16'h0008, 3'd4, 1'b0, 1'b0);
`ifdef AA_LINE_LATCH_EN
    exp_q.push_back({20'h00003, 8'h00, 1'b0, 1'b0});
`else
    exp_q.push_back({20'h00004, 8'h00, 1'b0, 1'b0});
`endif
    pop_head("line_aa");
    chk("end.empty", {31'd0, TILE_VALID}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
